// File: rtl/spi_pkg.sv
// Shared definitions for the 8-bit SPI link: byte width, mode constants and
// the peripheral state encoding.
package spi_pkg;

   localparam int SPI_BYTE_W    = 8;
   localparam bit SPI_CPOL      = 1'b0;
   localparam bit SPI_CPHA      = 1'b0;
   localparam bit SPI_MSB_FIRST = 1'b1;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pad input, plus an extra
// delay flop so the synchronized value yields single-cycle rise/fall strobes.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              dly;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= {STAGES{RST_VAL}};
         dly   <= RST_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         dly   <= chain[STAGES-1];
      end
   end

   assign sync = chain[STAGES-1];
   assign rise = sync & ~dly;
   assign fall = ~sync & dly;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI peripheral: oversamples sck/ss_n/mosi, assembles received bytes
// and shifts out bytes from a one-entry transmit buffer.
module spi_slave
   import spi_pkg::*;
#(
   parameter int                    SYNC_STAGES = 2,
   parameter logic [SPI_BYTE_W-1:0] DEFAULT_TX  = 8'hFF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sck,
   input  logic                  ss_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic [SPI_BYTE_W-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [SPI_BYTE_W-1:0] data_out,
   output logic                  new_data,
   output logic                  tx_underrun,
   output logic                  busy
);

   spi_state_e            state, state_next;
   logic                  sck_s, sck_rise, sck_fall;
   logic                  ss_s, ss_rise, ss_fall;
   logic                  mosi_s, mosi_rise, mosi_fall;
   logic [2:0]            bit_cnt;
   logic                  reload;
   logic [SPI_BYTE_W-1:0] rx_shift, tx_shift, buf_data, load_byte;
   logic                  buf_full;
   logic                  byte_load;
   logic                  unused_sync;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .clk(clk), .rst(rst), .din(sck), .sync(sck_s), .rise(sck_rise), .fall(sck_fall));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
      .clk(clk), .rst(rst), .din(ss_n), .sync(ss_s), .rise(ss_rise), .fall(ss_fall));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .din(mosi), .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

   assign unused_sync = ^{sck_s, ss_s, mosi_rise, mosi_fall};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // A byte starts on select, or on the first sck fall after a completed byte.
   // Deselect wins over a coincident sck fall, so the frame end never reloads.
   always_comb begin
      state_next = state;
      byte_load  = 1'b0;
      case (state)
         IDLE: begin
            if (ss_fall) begin
               state_next = ACTIVE;
               byte_load  = 1'b1;
            end
         end
         ACTIVE: begin
            if (ss_rise)                  state_next = IDLE;
            else if (sck_fall && reload)  byte_load  = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   assign load_byte = buf_full ? buf_data : DEFAULT_TX;

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt     <= '0;
         reload      <= 1'b0;
         rx_shift    <= '0;
         tx_shift    <= '0;
         buf_data    <= '0;
         buf_full    <= 1'b0;
         data_out    <= '0;
         new_data    <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         new_data    <= 1'b0;
         tx_underrun <= 1'b0;

         if (byte_load) begin
            tx_shift    <= load_byte;
            tx_underrun <= ~buf_full;
         end else if (state == ACTIVE && sck_fall && !ss_rise) begin
            tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
         end

         // An accept can only coincide with a load when the buffer is empty.
         if (tx_valid && !buf_full) begin
            buf_data <= tx_data;
            buf_full <= 1'b1;
         end else if (byte_load) begin
            buf_full <= 1'b0;
         end

         if (state == IDLE) begin
            if (ss_fall) begin
               bit_cnt  <= '0;
               reload   <= 1'b0;
               rx_shift <= '0;
            end
         end else begin
            if (sck_rise) begin
               rx_shift <= {rx_shift[SPI_BYTE_W-2:0], mosi_s};
               bit_cnt  <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  data_out <= {rx_shift[SPI_BYTE_W-2:0], mosi_s};
                  new_data <= 1'b1;
                  reload   <= 1'b1;
               end
            end
            if (byte_load) reload <= 1'b0;
            if (ss_rise) begin
               bit_cnt <= '0;
               reload  <= 1'b0;
            end
         end
      end
   end

   assign busy     = (state == ACTIVE);
   assign miso_oe  = busy;
   assign miso     = busy & tx_shift[SPI_BYTE_W-1];
   assign tx_ready = ~buf_full;

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI peripheral (target) end of the team's 8-bit SPI link. Mode 0 only: CPOL=0, CPHA=0, MSB first.
- Oversamples external sck/ss_n/mosi in the clk domain.
- Delivers each received byte with a one-cycle new_data pulse.
- Returns bytes from a one-entry transmit buffer loaded through a valid/ready handshake.
- Sits between the pads (external SPI bus master) and on-chip register/command logic.

Parameters:
- SYNC_STAGES, 2, number of flops in each input synchronizer (≥2).
- DEFAULT_TX, 8'hFF, byte shifted out when the transmit buffer is empty at byte start.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- sck  input  1  SPI clock from bus master (asynchronous to clk)
- ss_n  input  1  slave select, active-low (asynchronous)
- mosi  input  1  serial data from master (asynchronous)
- miso  output  1  serial data to master
- miso_oe  output  1  output enable for the miso pad; 1 only while selected
- tx_data  input  8  next byte to return
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  transmit buffer empty, can accept
- data_out  output  8  last complete received byte
- new_data  output  1  one-cycle pulse, data_out updated
- tx_underrun  output  1  one-cycle pulse, DEFAULT_TX substituted
- busy  output  1  transfer in progress (ACTIVE state)

Behaviour:
- Reset values:
  - miso=0, miso_oe=0, data_out=8'h00, new_data=0, tx_underrun=0, busy=0, tx_ready=1.
  - Transmit buffer empty, bit counter 0.
  - Synchronizer flops: sck 0, ss_n 1, mosi 0.
  - Reset mid-transfer drops all state immediately; the partial byte is lost.
- Synchronizers: sck, ss_n and mosi each pass through SYNC_STAGES flops. Edge detection compares the last stage against one extra delay flop.
  - sck_rise, sck_fall, ss_fall, ss_rise are single-cycle strobes.
- Input timing requirement: sck high and low phases each ≥ SYNC_STAGES+2 clk cycles; ss_n setup to first sck rise is the same. Faster buses are unsupported.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE on ss_fall:
  - Bit counter cleared to 0.
  - tx shift register loaded from the buffer, or with DEFAULT_TX if empty (then tx_underrun pulse).
  - miso_oe=1 and miso=shift[7] from the next cycle.
- ACTIVE, sck_rise:
  - rx shift <= {rx[6:0], mosi_sync}; counter++.
  - If counter was 7:
    - data_out <= {rx[6:0], mosi_sync}; new_data=1 for the following cycle.
    - Counter wraps to 0; set the reload flag.
- ACTIVE, sck_fall:
  - If the reload flag is set: load tx shift from the buffer (or DEFAULT_TX with tx_underrun pulse); clear the flag; miso=new shift[7].
  - Otherwise: tx shift <<= 1; miso = new shift[7].
- ACTIVE -> IDLE on ss_rise, any bit position:
  - Counter cleared, reload flag cleared, miso_oe=0, miso=0.
  - Partial rx bits discarded, no new_data.
  - data_out holds its last value.
- Simultaneous ss_rise and sck_rise on the 8th bit: the byte completes (new_data pulses), then IDLE.
- Transmit buffer:
  - tx_ready = buffer empty.
  - Accept on tx_valid && tx_ready.
  - Consumed only at byte start (ss_fall or reload-flag sck_fall).
  - A consume and an accept never coincide in the same cycle, because tx_ready is 0 whenever there is a byte to consume.
- busy=1 exactly while in ACTIVE.
- new_data and tx_underrun never stay high longer than 1 cycle.

Decomposition:
- Shared package spi_pkg:
  - State enum {IDLE, ACTIVE}.
  - SPI_BYTE_W=8.
  - SPI mode constants, shared with the existing SPI master.
- Sub-module spi_sync: one instance per input. Contains SYNC_STAGES flops plus the delay flop and outputs sync value, rise and fall. Reset value is a parameter so ss_n can reset to 1.

Test Plan:
1. Preload tx 8'hA5, master sends 8'h3C in one ss_n frame -> data_out=8'h3C with one new_data pulse; miso samples on sck rise read 8'hA5; tx_ready returns to 1 at ss_fall.
2. Two back-to-back bytes in one frame (mosi 8'h12 then 8'h34, tx preloaded 8'h01, then 8'h02 written after first new_data) -> new_data pulses twice (8'h12, 8'h34); master reads 8'h01, 8'h02; no tx_underrun.
3. Empty tx buffer at ss_fall, master sends 8'h55 -> one tx_underrun pulse; master reads 8'hFF; data_out=8'h55.
4. ss_n deasserted after 5 sck rises -> no new_data; data_out unchanged; miso_oe=0 and busy=0 within SYNC_STAGES+2 cycles of ss_n rise; next full frame of 8'hC3 received correctly.
5. rst asserted mid-byte (after 3 bits) -> next cycle all outputs at reset values, tx_ready=1; a subsequent frame of 8'h96 is received correctly.
6. tx_valid held high with 8'h77 while buffer full -> tx_ready=0 and no overwrite; previous buffered byte 8'hAA is shifted out first.
